// File: rtl/wbm_pkg.sv
// Shared constants for the Wishbone classic burst master: widths, defaults
// and the controller state encoding.
package wbm_pkg;
    localparam int unsigned WB_ADR_W     = 32;
    localparam int unsigned WB_DAT_W     = 32;
    localparam int unsigned WB_SEL_W     = WB_DAT_W / 8;
    localparam int unsigned LEN_W        = 8;
    localparam int unsigned TMO_W        = 8;
    localparam int unsigned TIMEOUT_DEF  = 255;
    localparam int unsigned ADR_STEP_DEF = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
endpackage

// File: rtl/wbm_ctrl.sv
// Command-to-Wishbone classic master: single writes and incrementing read
// bursts, one response per beat, with a per-beat ack timeout.
module wbm_ctrl
    import wbm_pkg::*;
#(
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
    parameter int unsigned ADR_STEP = ADR_STEP_DEF
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n_i,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [WB_ADR_W-1:0] cmd_adr,
    input  logic [WB_DAT_W-1:0] cmd_dat,
    input  logic [WB_SEL_W-1:0] cmd_sel,
    input  logic [LEN_W-1:0]    cmd_len,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WB_DAT_W-1:0] rsp_dat,
    output logic                rsp_err,
    output logic                rsp_last,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [WB_ADR_W-1:0] wbm_adr_o,
    output logic [WB_DAT_W-1:0] wbm_dat_o,
    output logic [WB_SEL_W-1:0] wbm_sel_o,
    input  logic                wbm_ack_i,
    input  logic [WB_DAT_W-1:0] wbm_dat_i
);
    localparam logic [TMO_W-1:0]    TMO_LIM = TMO_W'(TIMEOUT);
    localparam logic [WB_ADR_W-1:0] STEP    = WB_ADR_W'(ADR_STEP);

    logic [1:0]          state_q, state_d;
    logic                cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [WB_ADR_W-1:0] adr_q, adr_d;
    logic [WB_DAT_W-1:0] dat_q, dat_d;
    logic [WB_SEL_W-1:0] sel_q, sel_d;
    logic [LEN_W-1:0]    beats_q, beats_d;   // beats remaining after the current one
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, rsp_last_q, rsp_last_d;
    logic [WB_DAT_W-1:0] rsp_dat_q, rsp_dat_d;

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        beats_d     = beats_q;
        tmo_d       = tmo_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        rsp_last_d  = rsp_last_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    sel_d   = cmd_sel;
                    beats_d = cmd_we ? '0 : cmd_len;
                    tmo_d   = '0;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // An ack on the limit cycle wins over the timeout.
                if (wbm_ack_i) begin
                    stb_d       = 1'b0;
                    cyc_d       = (beats_q != '0);
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = we_q ? '0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_last_d  = (beats_q == '0);
                    state_d     = ST_RESP;
                end else if (tmo_q + TMO_W'(1) == TMO_LIM) begin
                    stb_d       = 1'b0;
                    cyc_d       = 1'b0;
                    beats_d     = '0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_last_d  = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        adr_d   = adr_q + STEP;
                        beats_d = beats_q - LEN_W'(1);
                        tmo_d   = '0;
                        stb_d   = 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            beats_q     <= '0;
            tmo_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            beats_q     <= beats_d;
            tmo_q       <= tmo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign cmd_ready = (state_q == ST_IDLE) && wb_rst_n_i;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_last  = rsp_last_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = sel_q;
endmodule

// File: tb/tb_wbm_ctrl.sv
// Bench for wbm_ctrl: command table with a scoreboarded Wishbone slave and
// response sink, plus hand sequences for reset corner cases.
module tb_wbm_ctrl;
    localparam int          TO   = 16;
    localparam logic [31:0] STEP = 32'd4;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n_i;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic [7:0]  cmd_len;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_last;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    wbm_ctrl #(.TIMEOUT(TO), .ADR_STEP(4)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_err(rsp_err), .rsp_last(rsp_last),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct { logic [31:0] adr; logic we; logic [31:0] dat; logic [3:0] sel; } stb_t;
    typedef struct { logic [31:0] dat; logic err; logic last; } rsp_t;
    typedef struct {
        logic we; logic [31:0] adr; logic [31:0] dat; logic [3:0] sel; logic [7:0] len;
        int ack_delay; logic ack_en; logic stray; int stall_beat; int stall_cycles;
        int exp_lat; int exp_stb;
    } vec_t;

    stb_t exp_stb[$];
    rsp_t exp_rsp[$];
    int   n_cmp = 0, n_bad = 0;
    int   n_done = 0, rsp_idx = 0;
    int   ack_delay = 0, stall_beat = 0, stall_cycles = 0;
    logic ack_en = 1'b1, stray_ack = 1'b0;
    vec_t vecs[10];

    function automatic void chk1(string name, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endfunction

    function automatic void chk32(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic void chki(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] mem_rd(logic [31:0] a);
        if (a == 32'h3000_0010) return 32'h1234_5678;
        return {a[15:0], 16'hC0DE} ^ 32'h0F0F_0000;
    endfunction

    // Wishbone slave: acks after ack_delay extra strobe cycles, checks each acked strobe.
    initial begin : slave
        int         stb_cycles;
        logic [31:0] a0, d0;
        logic [3:0] s0;
        logic       w0, moved;
        stb_t       e;
        stb_cycles = 0; moved = 1'b0; a0 = '0; d0 = '0; s0 = '0; w0 = 1'b0;
        wbm_ack_i = 1'b0; wbm_dat_i = '0;
        forever begin
            @(negedge wb_clk_i);
            if (!wb_rst_n_i || !(wbm_cyc_o && wbm_stb_o)) begin
                stb_cycles = 0;
                wbm_ack_i  = stray_ack && wb_rst_n_i;
                wbm_dat_i  = 32'hBAD0_BAD0;
            end else begin
                if (stb_cycles == 0) begin
                    a0 = wbm_adr_o; d0 = wbm_dat_o; s0 = wbm_sel_o; w0 = wbm_we_o; moved = 1'b0;
                end else if ({a0, d0, s0, w0} !== {wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o}) begin
                    moved = 1'b1;
                end
                stb_cycles++;
                if (ack_en && stb_cycles == ack_delay + 1) begin
                    wbm_ack_i = 1'b1;
                    chk1("stb_expected", exp_stb.size() > 0, 1'b1);
                    if (exp_stb.size() > 0) begin
                        e = exp_stb.pop_front();
                        $display("strobe adr=%08h we=%b dat=%08h sel=%h after %0d cycles",
                                 wbm_adr_o, wbm_we_o, wbm_dat_o, wbm_sel_o, stb_cycles);
                        chk32("stb_adr", wbm_adr_o, e.adr);
                        chk1("stb_we", wbm_we_o, e.we);
                        chk32("stb_sel", {28'd0, wbm_sel_o}, {28'd0, e.sel});
                        if (e.we) chk32("stb_dat", wbm_dat_o, e.dat);
                        chk1("stb_stable", moved, 1'b0);
                        wbm_dat_i = e.we ? 32'hFFFF_FFFF : mem_rd(e.adr);
                    end else begin
                        wbm_dat_i = 32'hBAD0_BAD0;
                    end
                end else begin
                    wbm_ack_i = 1'b0;
                    wbm_dat_i = 32'hBAD0_BAD0;
                end
            end
        end
    end

    // Response sink: applies backpressure on the chosen beat, scoreboards each handshake.
    initial begin : sink
        rsp_t e, h;
        logic held;
        int   stall_cnt;
        held = 1'b0; stall_cnt = 0; rsp_ready = 1'b0;
        h = '{32'h0, 1'b0, 1'b0};
        forever begin
            @(negedge wb_clk_i);
            if (!wb_rst_n_i) begin
                rsp_ready = 1'b0; held = 1'b0; stall_cnt = 0; rsp_idx = 0;
            end else begin
                if (held) begin
                    chk1("hold_valid", rsp_valid, 1'b1);
                    chk1("hold_no_stb", wbm_stb_o, 1'b0);
                    chk32("hold_dat", rsp_dat, h.dat);
                    chk1("hold_err", rsp_err, h.err);
                    chk1("hold_last", rsp_last, h.last);
                end
                if (rsp_valid) begin
                    chk1("rsp_expected", exp_rsp.size() > 0, 1'b1);
                    if (exp_rsp.size() > 0) begin
                        e = exp_rsp[0];
                        chk1("cyc_in_rsp", wbm_cyc_o, !e.last);
                        if (rsp_idx + 1 == stall_beat && stall_cnt < stall_cycles) begin
                            rsp_ready = 1'b0; stall_cnt++; held = 1'b1;
                            h.dat = rsp_dat; h.err = rsp_err; h.last = rsp_last;
                        end else begin
                            rsp_ready = 1'b1; held = 1'b0;
                            void'(exp_rsp.pop_front());
                            $display("response dat=%08h err=%b last=%b", rsp_dat, rsp_err, rsp_last);
                            chk32("rsp_dat", rsp_dat, e.dat);
                            chk1("rsp_err", rsp_err, e.err);
                            chk1("rsp_last", rsp_last, e.last);
                            rsp_idx++;
                            if (e.last) begin
                                rsp_idx = 0; stall_cnt = 0; n_done++;
                            end
                        end
                    end else begin
                        rsp_ready = 1'b1;
                    end
                end else begin
                    rsp_ready = 1'b1; held = 1'b0;
                end
            end
        end
    end

    task automatic push_expect(input vec_t v);
        int          beats;
        logic [31:0] a;
        beats = v.we ? 1 : int'(v.len) + 1;
        if (!v.ack_en) begin
            exp_rsp.push_back('{32'h0, 1'b1, 1'b1});
        end else begin
            for (int b = 0; b < beats; b++) begin
                a = v.adr + 32'(b) * STEP;
                exp_stb.push_back('{a, v.we, v.dat, v.sel});
                exp_rsp.push_back('{v.we ? 32'h0 : mem_rd(a), 1'b0, b == beats - 1});
            end
        end
    endtask

    // Drives one command and returns at negedge+1 of the cycle after acceptance.
    task automatic issue(input vec_t v, input string tag);
        int k;
        ack_delay = v.ack_delay; ack_en = v.ack_en; stray_ack = v.stray;
        stall_beat = v.stall_beat; stall_cycles = v.stall_cycles;
        k = 0;
        while (!cmd_ready && k < 100) begin
            @(negedge wb_clk_i); #1; k++;
        end
        chk1({tag, "_idle_ready"}, cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.dat;
        cmd_sel = v.sel; cmd_len = v.len;
        @(negedge wb_clk_i); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_cmd(input vec_t v, input string tag);
        int   k, lat, stbs, done0;
        logic busy_rdy;
        done0 = n_done; lat = -1; stbs = 0; busy_rdy = 1'b0;
        push_expect(v);
        issue(v, tag);
        k = 1;
        while (1) begin
            if (cmd_ready) busy_rdy = 1'b1;
            if (wbm_stb_o) stbs++;
            if (rsp_valid && lat < 0) lat = k;
            if (n_done != done0 || k >= 1000) break;
            @(negedge wb_clk_i); #1; k++;
        end
        $display("cmd %s we=%b adr=%08h len=%0d: latency %0d, strobe cycles %0d",
                 tag, v.we, v.adr, v.len, lat, stbs);
        chk1({tag, "_completed"}, n_done != done0, 1'b1);
        chki({tag, "_latency"}, lat, v.exp_lat);
        chki({tag, "_stb_cycles"}, stbs, v.exp_stb);
        chk1({tag, "_ready_while_busy"}, busy_rdy, 1'b0);
        chki({tag, "_stb_left"}, exp_stb.size(), 0);
        @(negedge wb_clk_i); #1;
        chk1({tag, "_ready_after"}, cmd_ready, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        chk32({tag, "_adr"}, wbm_adr_o, 32'h0);
        chk32({tag, "_wdat"}, wbm_dat_o, 32'h0);
        chk32({tag, "_rdat"}, rsp_dat, 32'h0);
        chk32({tag, "_flags"}, {21'd0, wbm_sel_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
                                rsp_valid, rsp_err, rsp_last, cmd_ready}, 32'h0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t vr;
        int   k;
        // we, adr, dat, sel, len, delay, ack_en, stray, stall_beat, stall_cyc, lat, stb
        vecs[0] = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 8'd0, 2,  1'b1, 1'b0, 0, 0, 4,  3};
        vecs[1] = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 8'd0, 0,  1'b1, 1'b0, 0, 0, 2,  1};
        vecs[2] = '{1'b0, 32'h3000_0100, 32'h0,         4'hF, 8'd3, 1,  1'b1, 1'b0, 0, 0, 3,  8};
        vecs[3] = '{1'b0, 32'h3000_0200, 32'h0,         4'hF, 8'd3, 0,  1'b1, 1'b0, 2, 5, 2,  4};
        vecs[4] = '{1'b0, 32'h3000_0020, 32'h0,         4'hF, 8'd0, 15, 1'b1, 1'b0, 0, 0, 17, 16};
        vecs[5] = '{1'b0, 32'h3000_0024, 32'h0,         4'hF, 8'd0, 14, 1'b1, 1'b0, 0, 0, 16, 15};
        vecs[6] = '{1'b1, 32'h3000_0040, 32'h5566_7788, 4'h3, 8'd5, 0,  1'b1, 1'b1, 0, 0, 2,  1};
        vecs[7] = '{1'b0, 32'hFFFF_FFF8, 32'h0,         4'hF, 8'd2, 0,  1'b1, 1'b1, 0, 0, 2,  3};
        vecs[8] = '{1'b0, 32'h3000_0300, 32'h0,         4'hF, 8'd2, 0,  1'b0, 1'b0, 0, 0, 17, 16};
        vecs[9] = '{1'b0, 32'h3000_0080, 32'h0,         4'hF, 8'd0, 3,  1'b1, 1'b0, 0, 0, 5,  4};

        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0; cmd_len = '0;
        wb_rst_n_i = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        #1;
        check_all_zero("reset");
        wb_rst_n_i = 1'b1;
        @(negedge wb_clk_i); #1;
        chk1("reset_ready_after", cmd_ready, 1'b1);

        for (int i = 0; i < 10; i++) begin
            do_cmd(vecs[i], $sformatf("v%0d", i));
        end

        // Reset while the second beat of a burst is strobing.
        vr = '{1'b0, 32'h3000_0400, 32'h0, 4'hF, 8'd3, 2, 1'b1, 1'b0, 0, 0, 0, 0};
        push_expect(vr);
        issue(vr, "midrst");
        k = 0;
        while (!(rsp_idx == 1 && wbm_stb_o) && k < 200) begin
            @(negedge wb_clk_i); #1; k++;
        end
        chk1("midrst_beat2", rsp_idx == 1 && wbm_stb_o, 1'b1);
        #2;
        wb_rst_n_i = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_stb.delete();
        exp_rsp.delete();
        @(negedge wb_clk_i); #1;
        @(negedge wb_clk_i); #1;
        wb_rst_n_i = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        #1;
        chk1("midrst_no_rsp", rsp_valid, 1'b0);
        chk1("midrst_ready", cmd_ready, 1'b1);
        do_cmd(vecs[1], "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
